// File: rtl/execute_stage.sv
// RV32-style execute stage: ID/EX pipeline register, operand forwarding muxes and ALU.
// Reset, flush and stall act on the ID/EX register; everything downstream of it is combinational.
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic [3:0]      ALUControlD,
    input  logic [1:0]      ALUSrcD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic            ZeroE,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
);

    logic            valid_p1;
    logic            regwrite_p1;
    logic [3:0]      aluctrl_p1;
    logic [1:0]      alusrc_p1;
    logic [XLEN-1:0] rd1_p1;
    logic [XLEN-1:0] rd2_p1;
    logic [XLEN-1:0] imm_p1;
    logic [XLEN-1:0] pc_p1;
    logic [4:0]      rs1_p1;
    logic [4:0]      rs2_p1;
    logic [4:0]      rd_p1;

    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            unused_alusrc1;

    function automatic logic [XLEN-1:0] alu(input logic [3:0]      op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b,
                                            input logic [XLEN-1:0] imm,
                                            input logic [XLEN-1:0] pc);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [4:0]             shamt;
        logic [XLEN-1:0]        r;
        sa    = $signed(a);
        sb    = $signed(b);
        shamt = b[4:0];
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: r = {{(XLEN-1){1'b0}}, (sa < sb)};
            4'b0110: r = a << shamt;
            4'b0111: r = a >> shamt;
            4'b1000: r = sa >>> shamt;
            4'b1001: r = {{(XLEN-1){1'b0}}, (a < b)};
            4'b1011: r = imm;
            4'b1100: r = pc + imm;
            default: r = '0;
        endcase
        return r;
    endfunction

    // ID/EX boundary: reset and flush both load the all-zero bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset || FlushE) begin
            valid_p1    <= 1'b0;
            regwrite_p1 <= 1'b0;
            aluctrl_p1  <= '0;
            alusrc_p1   <= '0;
            rd1_p1      <= '0;
            rd2_p1      <= '0;
            imm_p1      <= '0;
            pc_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
        end else if (!StallE) begin
            valid_p1    <= ValidD;
            regwrite_p1 <= RegWriteD;
            aluctrl_p1  <= ALUControlD;
            alusrc_p1   <= ALUSrcD;
            rd1_p1      <= RD1D;
            rd2_p1      <= RD2D;
            imm_p1      <= ImmExtD;
            pc_p1       <= PCD;
            rs1_p1      <= Rs1D;
            rs2_p1      <= Rs2D;
            rd_p1       <= RdD;
        end
    end

    // EX boundary: forwarding and ALU, combinational from ID/EX state
    always_comb begin
        case (ForwardAE)
            2'b01:   srca = ResultW;
            2'b10:   srca = ALUResultM;
            default: srca = rd1_p1;
        endcase
        case (ForwardBE)
            2'b01:   WriteDataE = ResultW;
            2'b10:   WriteDataE = ALUResultM;
            default: WriteDataE = rd2_p1;
        endcase
    end

    assign srcb       = alusrc_p1[0] ? imm_p1 : WriteDataE;
    assign ALUResultE = alu(aluctrl_p1, srca, srcb, imm_p1, pc_p1);
    assign ZeroE      = (ALUResultE == '0);

    // A write from an invalid slot must never reach the register file
    assign ValidE     = valid_p1;
    assign RegWriteE  = regwrite_p1 & valid_p1;
    assign Rs1E       = rs1_p1;
    assign Rs2E       = rs2_p1;
    assign RdE        = rd_p1;

    assign unused_alusrc1 = alusrc_p1[1];

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU/forwarding vector table plus reset, stall and flush sequences.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallE, FlushE, ValidD, RegWriteD;
    logic [3:0]  ALUControlD;
    logic [1:0]  ALUSrcD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultM, ResultW;
    logic [31:0] ALUResultE, WriteDataE;
    logic        ZeroE, ValidE, RegWriteE;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  src;
        logic [31:0] rd1, rd2, imm, pc;
        logic [1:0]  fa, fb;
        logic [31:0] exp_res, exp_wd;
    } vec_t;

    vec_t tbl[$];

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .ValidD(ValidD), .RegWriteD(RegWriteD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .ZeroE(ZeroE),
        .ValidE(ValidE), .RegWriteE(RegWriteE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic addv(input logic [3:0] op, input logic [1:0] src,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [31:0] er, input logic [31:0] ew);
        vec_t v;
        v.op = op; v.src = src; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pc = pc;
        v.fa = fa; v.fb = fb; v.exp_res = er; v.exp_wd = ew;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] src,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [4:0] rd);
        ValidD = 1'b1; RegWriteD = 1'b1; ALUControlD = op; ALUSrcD = src;
        RD1D = rd1; RD2D = rd2; ImmExtD = 32'h0; PCD = 32'h0;
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = rd;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    task automatic expect_bubble(input string tag);
        chk({tag, "_valid"}, {31'b0, ValidE}, 32'd0);
        chk({tag, "_regwr"}, {31'b0, RegWriteE}, 32'd0);
        chk({tag, "_res"}, ALUResultE, 32'h0);
        chk({tag, "_zero"}, {31'b0, ZeroE}, 32'd1);
        chk({tag, "_rd"}, {27'b0, RdE}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        drive(4'b0000, 2'b00, 32'h5, 32'h6, 5'd3);
        ALUResultM = 32'd9; ResultW = 32'd7;

        // ALU sweep on 0x8000_0000 / 1
        addv(4'b0000, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h8000_0001, 32'h1);
        addv(4'b0001, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h7FFF_FFFF, 32'h1);
        addv(4'b0010, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h0000_0000, 32'h1);
        addv(4'b0011, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h8000_0001, 32'h1);
        addv(4'b0100, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h8000_0001, 32'h1);
        addv(4'b0101, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h0000_0001, 32'h1);
        addv(4'b0110, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h0000_0000, 32'h1);
        addv(4'b0111, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h4000_0000, 32'h1);
        addv(4'b1000, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'hC000_0000, 32'h1);
        addv(4'b1001, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h0000_0000, 32'h1);
        addv(4'b1010, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h0000_0000, 32'h1);
        addv(4'b1101, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h0000_0000, 32'h1);
        addv(4'b1110, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h0000_0000, 32'h1);
        addv(4'b1111, 2'b00, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 2'b00, 32'h0000_0000, 32'h1);
        // sltu true case and shift amount taken from low 5 bits only
        addv(4'b1001, 2'b00, 32'h1, 32'h8000_0000, 0, 0, 2'b00, 2'b00, 32'h0000_0001, 32'h8000_0000);
        addv(4'b0110, 2'b00, 32'hA5, 32'h20, 0, 0, 2'b00, 2'b00, 32'h0000_00A5, 32'h20);
        addv(4'b1000, 2'b00, 32'h8000_0000, 32'h3F, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'h3F);
        // lui / auipc
        addv(4'b1011, 2'b00, 32'h0, 32'h0, 32'h1234_5000, 32'h100, 2'b00, 2'b00, 32'h1234_5000, 32'h0);
        addv(4'b1100, 2'b00, 32'h0, 32'h0, 32'h1234_5000, 32'h100, 2'b00, 2'b00, 32'h1234_5100, 32'h0);
        // SrcA forwarding with SrcB = imm 0
        addv(4'b0000, 2'b01, 32'd5, 32'd3, 0, 0, 2'b10, 2'b00, 32'd9, 32'd3);
        addv(4'b0000, 2'b01, 32'd5, 32'd3, 0, 0, 2'b01, 2'b00, 32'd7, 32'd3);
        addv(4'b0000, 2'b01, 32'd5, 32'd3, 0, 0, 2'b11, 2'b00, 32'd5, 32'd3);
        // SrcB / WriteData forwarding with SrcA = 0
        addv(4'b0000, 2'b00, 32'd0, 32'd3, 0, 0, 2'b00, 2'b10, 32'd9, 32'd9);
        addv(4'b0000, 2'b00, 32'd0, 32'd3, 0, 0, 2'b00, 2'b01, 32'd7, 32'd7);
        addv(4'b0000, 2'b00, 32'd0, 32'd3, 0, 0, 2'b00, 2'b11, 32'd3, 32'd3);
        // wrap to zero; auipc wrap
        addv(4'b0000, 2'b01, 32'hFFFF_FFFF, 32'h0, 32'h1, 0, 2'b00, 2'b00, 32'h0, 32'h0);
        addv(4'b1100, 2'b00, 32'h0, 32'h0, 32'hFFFF_FF00, 32'h200, 2'b00, 2'b00, 32'h100, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_bubble("reset_hold");
        reset = 1'b0;

        // Table
        for (int i = 0; i < tbl.size(); i++) begin
            ValidD = 1'b1; RegWriteD = 1'b1;
            ALUControlD = tbl[i].op; ALUSrcD = tbl[i].src;
            RD1D = tbl[i].rd1; RD2D = tbl[i].rd2; ImmExtD = tbl[i].imm; PCD = tbl[i].pc;
            Rs1D = 5'(i); Rs2D = 5'(i + 2); RdD = 5'(i + 1);
            ForwardAE = tbl[i].fa; ForwardBE = tbl[i].fb;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_res", i), ALUResultE, tbl[i].exp_res);
            chk($sformatf("vec%0d_wd", i), WriteDataE, tbl[i].exp_wd);
            chk($sformatf("vec%0d_zero", i), {31'b0, ZeroE}, {31'b0, tbl[i].exp_res == 32'h0});
            chk($sformatf("vec%0d_idx", i), {17'b0, Rs1E, Rs2E, RdE},
                {17'b0, 5'(i), 5'(i + 2), 5'(i + 1)});
            chk($sformatf("vec%0d_ctl", i), {30'b0, ValidE, RegWriteE}, 32'd3);
        end

        // Invalid slot must not write
        drive(4'b0000, 2'b00, 32'h1, 32'h1, 5'd4);
        ValidD = 1'b0;
        @(posedge clk);
        #1;
        chk("invalid_regwr", {31'b0, RegWriteE}, 32'd0);
        chk("invalid_valid", {31'b0, ValidE}, 32'd0);

        // Reset asserted mid-cycle with a valid add loaded
        drive(4'b0000, 2'b00, 32'h5, 32'h6, 5'd3);
        @(posedge clk);
        #1;
        chk("pre_reset_res", ALUResultE, 32'd11);
        #2 reset = 1'b1;
        #1;
        expect_bubble("async_reset");
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_load", ALUResultE, 32'd11);
        chk("post_reset_valid", {31'b0, ValidE}, 32'd1);

        // Stall holds sub 3-3 against new inputs, then flush beats stall
        drive(4'b0001, 2'b00, 32'd3, 32'd3, 5'd7);
        @(posedge clk);
        #1;
        chk("sub_res", ALUResultE, 32'd0);
        chk("sub_zero", {31'b0, ZeroE}, 32'd1);
        StallE = 1'b1;
        drive(4'b0000, 2'b00, 32'd1, 32'd2, 5'd9);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_res", k), ALUResultE, 32'd0);
            chk($sformatf("stall%0d_zero", k), {31'b0, ZeroE}, 32'd1);
            chk($sformatf("stall%0d_rd", k), {27'b0, RdE}, 32'd7);
            chk($sformatf("stall%0d_valid", k), {31'b0, ValidE}, 32'd1);
        end
        FlushE = 1'b1;
        @(posedge clk);
        #1;
        expect_bubble("flush_over_stall");
        StallE = 1'b0; FlushE = 1'b0;
        @(posedge clk);
        #1;
        chk("after_flush_res", ALUResultE, 32'd3);

        // Reset during a stall discards the held instruction
        StallE = 1'b1;
        drive(4'b0000, 2'b00, 32'd20, 32'd22, 5'd5);
        @(posedge clk);
        #1;
        chk("stall_kept_res", ALUResultE, 32'd3);
        #2 reset = 1'b1;
        #1;
        expect_bubble("reset_in_stall");
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        expect_bubble("stall_after_reset");
        StallE = 1'b0;
        @(posedge clk);
        #1;
        chk("resume_res", ALUResultE, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all ID/EX state immediately, independent of clk.
REQ-004 StallE  in  1  hold ID/EX register contents.
REQ-005 FlushE  in  1  load a bubble into the ID/EX register.
REQ-006 ValidD  in  1  decode-stage instruction valid.
REQ-007 RegWriteD  in  1  decode-stage register-write enable.
REQ-008 ALUControlD  in  4  ALU operation from ALU decoder.
REQ-009 ALUSrcD  in  2  bit0: SrcB = ImmExt, else forwarded rs2; bit1 is carried but unused here.
REQ-010 RD1D, RD2D, ImmExtD, PCD  in  XLEN each  register-file operands, extended immediate, PC.
REQ-011 Rs1D, Rs2D, RdD  in  5 each  source and destination register indices.
REQ-012 ForwardAE, ForwardBE  in  2 each  forwarding selects: 00 register, 01 ResultW, 10 ALUResultM, 11 register.
REQ-013 ALUResultM, ResultW  in  XLEN each  MEM and WB forwarding sources.
REQ-014 ALUResultE  out  XLEN  ALU result.
REQ-015 WriteDataE  out  XLEN  forwarded rs2 value (store data).
REQ-016 ZeroE  out  1  ALUResultE == 0.
REQ-017 ValidE, RegWriteE  out  1 each  registered valid and write enable.
REQ-018 Rs1E, Rs2E, RdE  out  5 each  registered indices, used by the hazard unit.

Function
REQ-019 On each rising edge with reset low, the ID/EX register SHALL take: FlushE=1 -> bubble; else StallE=1 -> hold; else load all D-suffixed inputs.
REQ-020 FlushE SHALL take priority over StallE when both are high.
REQ-021 A bubble SHALL be all fields zero, i.e. ValidE=0, RegWriteE=0, ALUControlE=0000, RdE=0.
REQ-022 SrcAE SHALL be RD1E, ResultW or ALUResultM per ForwardAE; 11 SHALL select RD1E.
REQ-023 WriteDataE SHALL be RD2E, ResultW or ALUResultM per ForwardBE; 11 SHALL select RD2E.
REQ-024 SrcBE SHALL be ImmExtE when ALUSrcE[0]=1, else WriteDataE.
REQ-025 Latency: outputs SHALL reflect an instruction one edge after capture; ALU and forwarding paths are combinational from ID/EX state and the forwarding inputs.
REQ-026 ALU ops: 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor; 0101 signed SrcA<SrcB ? 1 : 0; 0110 SrcA << SrcB[4:0]; 0111 logical >>; 1000 arithmetic >>; 1001 unsigned less-than; 1011 result = ImmExtE (lui); 1100 result = PCE + ImmExtE (auipc).
REQ-027 Unused encodings 1010, 1101, 1110, 1111 SHALL give ALUResultE = 0.
REQ-028 add, sub and auipc SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-029 Shifts SHALL use only SrcB[4:0]; a shift amount of 0 returns SrcA unchanged.
REQ-030 ZeroE SHALL be computed from ALUResultE for every op, including bubbles (bubble -> add 0+0 -> ZeroE=1).
REQ-031 RegWriteE SHALL be 0 whenever ValidE=0.

Reset
REQ-032 While reset is high, the ID/EX register SHALL hold the bubble value (REQ-021) regardless of clk, StallE or FlushE.
REQ-033 When reset asserts mid-stall, the held instruction SHALL be discarded.
REQ-034 After reset deasserts, the first rising edge SHALL load per REQ-019.

Verification
REQ-035 Reset: assert reset mid-cycle with a valid add loaded -> ValidE=0, RegWriteE=0, ALUResultE=0, ZeroE=1 before the next edge.
REQ-036 ALU sweep: RD1D=0x8000_0000, RD2D=0x0000_0001, ALUSrcD=0; apply each encoding -> add 0x8000_0001; sub 0x7FFF_FFFF; slt 1; sltu 0; sra 0xC000_0000; srl 0x4000_0000; sll 0x0000_0000; unused 1101 -> 0.
REQ-037 U-type: ImmExtD=0x1234_5000, PCD=0x0000_0100 -> lui 0x1234_5000, auipc 0x1234_5100.
REQ-038 Forwarding: RD1D=5, ALUResultM=9, ResultW=7; ForwardAE=10 -> add with SrcB=0 gives 9; 01 gives 7; 11 gives 5; repeat for ForwardBE -> WriteDataE matches.
REQ-039 Stall/flush: load sub 3-3 (ZeroE=1), then StallE=1 for 2 cycles with new inputs -> outputs unchanged; StallE=1 and FlushE=1 together -> bubble on the next edge.
REQ-040 Wrap: RD1D=0xFFFF_FFFF, ImmExtD=1, ALUSrcD=01, add -> ALUResultE=0, ZeroE=1.
